rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single-ported, combinational-read instruction ROM between two requesters.
- Requester IF is the instruction-fetch port. Requester LD is a data-load port for constant tables and literal pools.
- Arbitrates each cycle, drives the ROM address, and registers the ROM word into a 1-cycle-latency response.
- For LD, extracts and extends byte/half/word. Flags misaligned and out-of-range accesses.

Parameters:
- ADDR_W, 32, address width of both requesters and the ROM.
- ROM_BYTES, 4096, ROM size in bytes; valid byte addresses are 0..ROM_BYTES-1.
- STARVE_MAX, 3, maximum consecutive cycles IF may be denied while requesting.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- if_req_i  in  1  fetch request; held with if_addr_i until granted.
- if_addr_i  in  ADDR_W  fetch byte address.
- if_gnt_o  out  1  fetch granted this cycle (combinational).
- if_rvalid_o  out  1  fetch response valid (registered).
- if_rdata_o  out  32  fetched instruction.
- if_err_o  out  1  fetch response is an error; qualified by if_rvalid_o.
- ld_req_i  in  1  load request; held with addr/size/unsigned until granted.
- ld_addr_i  in  ADDR_W  load byte address.
- ld_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
- ld_unsigned_i  in  1  1 = zero-extend, 0 = sign-extend.
- ld_gnt_o  out  1  load granted this cycle (combinational).
- ld_rvalid_o  out  1  load response valid (registered).
- ld_rdata_o  out  32  extended load data.
- ld_err_o  out  1  load response is an error; qualified by ld_rvalid_o.
- rom_a_o  out  ADDR_W  address to ROM (combinational).
- rom_rd_i  in  32  ROM word: {byte[a], byte[a+1], byte[a+2], byte[a+3]}.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values:
  - All rvalid/err outputs are 0; rdata outputs are 0.
  - Starvation counter is 0; FSM is in LD_PRIO.
  - While rst_i=1, both gnt outputs are forced to 0 and rom_a_o = 0.
- Reset mid-operation: a grant issued the cycle before reset has its response suppressed. rvalid stays 0 after reset and is not replayed.
- FSM:
  - LD_PRIO:
    - If both requesters request, LD wins; otherwise the sole requester wins.
    - A cycle where IF requests and is not granted increments starve_cnt.
    - A cycle where IF is granted, or does not request, clears starve_cnt.
    - When starve_cnt reaches STARVE_MAX with if_req_i still high, go to IF_PRIO.
  - IF_PRIO:
    - IF wins whenever it requests.
    - Return to LD_PRIO on the cycle IF is granted, or on any cycle if_req_i=0; starve_cnt is cleared.
- Grant rules:
  - At most one gnt per cycle.
  - gnt is never asserted without the matching req.
  - A grant is issued every cycle in which any req is high.
- rom_a_o: the granted requester's address; holds the LD address when idle.
- Response latency: on the edge after a grant, exactly one of if_rvalid_o / ld_rvalid_o is high for exactly 1 cycle. Back-to-back grants give back-to-back responses.
- Error checks, evaluated at grant time:
  - IF: error if if_addr_i[1:0] != 0 or if_addr_i > ROM_BYTES-4.
  - LD misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - LD reserved size: ld_size_i = 11 is an error.
  - LD out of range: addr + bytes(size) - 1 > ROM_BYTES-1. Compute with ADDR_W+1 bits so there is no wrap at 0xFFFFFFFF.
  - On error: err=1, rdata=0. The ROM is still addressed, but its value is discarded.
- LD extraction (byte at address a is rom_rd_i[31:24]):
  - Byte: ld_rdata_o = ext(rom_rd_i[31:24]).
  - Half: ld_rdata_o = ext(rom_rd_i[31:16]).
  - Word: ld_rdata_o = rom_rd_i.
  - ext is sign- or zero-extension per ld_unsigned_i captured at grant.
- Request attributes (size, unsigned, error) are registered alongside rom_rd_i at grant.
- if_rdata_o and ld_rdata_o hold their last value when the matching rvalid is 0.

Decomposition:
- Package rom_arb_pkg:
  - ld_size_e (SZ_B, SZ_H, SZ_W, SZ_RSVD).
  - arb_state_e (LD_PRIO, IF_PRIO).
  - Function size_bytes(ld_size_e).
- Sub-module ld_extend: combinational; inputs word, size, unsigned; output 32-bit extended data. Instantiated once on the registered LD path.

Test Plan:
- Single IF, ROM word 0x00500093 at addr 0x10: if_req_i=1, addr 0x10 -> if_gnt_o=1 in cycle 0; next cycle if_rvalid_o=1, if_rdata_o=0x00500093, if_err_o=0.
- Contention:
  - Stimulus: IF and LD both request continuously, STARVE_MAX=3.
  - Grants must be LD, LD, LD, then IF; the pattern repeats.
  - Responses must each arrive 1 cycle after their grant, never two rvalid in the same cycle.
- LD extension, bytes at 0x20..0x23 = 80 7F 12 34:
  - byte signed -> 0xFFFFFF80.
  - byte unsigned -> 0x00000080.
  - half signed at 0x20 -> 0xFFFF807F.
  - word -> 0x807F1234.
- Errors:
  - LD word at 0x22 -> ld_err_o=1, data 0.
  - LD half at 0xFFF -> err.
  - LD byte at 0xFFF -> ok.
  - IF at 0xFFC -> ok; IF at 0x1000 -> err.
  - ld_size_i=11 -> err.
  - LD word at 0xFFFFFFFC -> err (no wrap).
- Reset: grant LD in cycle N, assert rst_i in cycle N+1 -> ld_rvalid_o=0 at N+1 and N+2, gnts=0 during reset, starve_cnt cleared (next contention gives LD×3 then IF).

Source files
------------

// File: rtl/rom_arb_pkg.sv
// -----------------------------------------------------------------------------
// rom_arb_pkg
//   Shared types for the instruction-ROM arbiter.
//   - ld_size_e   : load access size as encoded on ld_size_i
//   - arb_state_e : arbitration priority state
//   - size_bytes  : number of bytes touched by a load of a given size
// -----------------------------------------------------------------------------
package rom_arb_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_B    = 2'b00,
    SZ_H    = 2'b01,
    SZ_W    = 2'b10,
    SZ_RSVD = 2'b11
  } ld_size_e;

  typedef enum logic {
    LD_PRIO = 1'b0,
    IF_PRIO = 1'b1
  } arb_state_e;

  // The reserved encoding reports 4 bytes so the range check stays
  // conservative; the access is flagged as an error independently.
  function automatic logic [2:0] size_bytes(input ld_size_e size);
    case (size)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      SZ_W:    size_bytes = 3'd4;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/ld_extend.sv
// -----------------------------------------------------------------------------
// ld_extend
//   Combinational load-data extraction. The byte at the requested address is
//   word[31:24], so byte/half loads take the top of the ROM word.
//   Ports:
//     word     in  32  registered ROM word
//     size     in  2   access size (ld_size_e)
//     zero_ext in  1   1 = zero-extend, 0 = sign-extend
//     data     out 32  extended load data
// -----------------------------------------------------------------------------
module ld_extend
  import rom_arb_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  ld_size_e          size,
  input  logic              zero_ext,
  output logic [DATA_W-1:0] data
);

  logic sign;

  // Both byte and half sign bits live in word[31].
  assign sign = ~zero_ext & word[31];

  always_comb begin
    data = word;
    case (size)
      SZ_B:    data = {{24{sign}}, word[31:24]};
      SZ_H:    data = {{16{sign}}, word[31:16]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//   Shares a single-ported, combinational-read instruction ROM between the
//   instruction-fetch port (IF) and a data-load port (LD). One grant per cycle,
//   ROM word registered into a 1-cycle-latency response. LD data is extracted
//   and extended; misaligned / out-of-range / reserved-size accesses are flagged.
//
//   Handshake: a requester raises req with its attributes and holds them until
//   gnt is seen high in the same cycle (gnt is combinational). Exactly one
//   cycle after a grant the matching rvalid is high for one cycle with rdata
//   and err; rdata/err hold their value while rvalid is low.
//
//   Ports:
//     clk_i, rst_i             clock, synchronous active-high reset
//     if_req_i / if_addr_i     fetch request and byte address
//     if_gnt_o                 fetch granted this cycle
//     if_rvalid_o/_rdata_o/_err_o  fetch response
//     ld_req_i / ld_addr_i / ld_size_i / ld_unsigned_i  load request
//     ld_gnt_o                 load granted this cycle
//     ld_rvalid_o/_rdata_o/_err_o  load response
//     rom_a_o / rom_rd_i       ROM address out, ROM word in
//     dbg_state_o              arbitration state
//     dbg_starve_cnt_o         consecutive IF denials (zero-extended)
// -----------------------------------------------------------------------------
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ROM_BYTES  = 4096,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  output logic              if_err_o,

  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [1:0]        ld_size_i,
  input  logic              ld_unsigned_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  output logic [31:0]       ld_rdata_o,
  output logic              ld_err_o,

  output logic [ADDR_W-1:0] rom_a_o,
  input  logic [31:0]       rom_rd_i,

  output arb_state_e        dbg_state_o,
  output logic [7:0]        dbg_starve_cnt_o
);

  localparam int unsigned CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Range limits carried at ADDR_W+1 bits so address arithmetic near the top
  // of the address space cannot wrap back into the ROM.
  localparam logic [ADDR_W:0] ROM_LAST = (ADDR_W + 1)'(ROM_BYTES - 1);
  localparam logic [ADDR_W:0] IF_LAST  = (ADDR_W + 1)'(ROM_BYTES - 4);

  // ---------------------------------------------------------------------------
  // Arbitration state
  // ---------------------------------------------------------------------------
  arb_state_e       state;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_inc;

  logic if_gnt;
  logic ld_gnt;

  assign starve_inc = starve_cnt + 1'b1;

  // IF wins when LD is idle, or when IF has earned priority.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!rst_i) begin
      if (if_req_i && (state == IF_PRIO || !ld_req_i)) begin
        if_gnt = 1'b1;
      end else if (ld_req_i) begin
        ld_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= LD_PRIO;
      starve_cnt <= '0;
    end else begin
      case (state)
        LD_PRIO: begin
          if (if_req_i && !if_gnt) begin
            starve_cnt <= starve_inc;
            if (starve_inc >= STARVE_LIM) begin
              state <= IF_PRIO;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        IF_PRIO: begin
          // IF is either granted here or not requesting: both end priority.
          state      <= LD_PRIO;
          starve_cnt <= '0;
        end
        default: begin
          state      <= LD_PRIO;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  assign if_gnt_o         = if_gnt;
  assign ld_gnt_o         = ld_gnt;
  assign dbg_state_o      = state;
  assign dbg_starve_cnt_o = 8'(starve_cnt);

  // The ROM follows LD when nobody is granted.
  assign rom_a_o = rst_i ? '0 : (if_gnt ? if_addr_i : ld_addr_i);

  // ---------------------------------------------------------------------------
  // Access checks, evaluated on the live request at grant time
  // ---------------------------------------------------------------------------
  ld_size_e        ld_size;
  logic            if_err;
  logic            ld_err;
  logic            ld_misaligned;
  logic [ADDR_W:0] ld_end;

  assign ld_size = ld_size_e'(ld_size_i);

  assign if_err = (if_addr_i[1:0] != 2'b00) || ({1'b0, if_addr_i} > IF_LAST);

  assign ld_end = {1'b0, ld_addr_i} + (ADDR_W + 1)'(size_bytes(ld_size))
                  - (ADDR_W + 1)'(1);

  assign ld_misaligned = ((ld_size == SZ_H) && ld_addr_i[0]) ||
                         ((ld_size == SZ_W) && (ld_addr_i[1:0] != 2'b00));

  assign ld_err = ld_misaligned || (ld_size == SZ_RSVD) || (ld_end > ROM_LAST);

  // ---------------------------------------------------------------------------
  // Response registers
  // ---------------------------------------------------------------------------
  logic        if_rvalid_q;
  logic        if_err_q;
  logic [31:0] if_rdata_q;

  logic        ld_rvalid_q;
  logic        ld_err_q;
  logic [31:0] ld_word_q;
  ld_size_e    ld_size_q;
  logic        ld_zext_q;
  logic [31:0] ld_data;

  // On error the captured word is zeroed, which makes the extended LD data
  // zero for every size without a separate mask.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ld_rvalid_q <= 1'b0;
      ld_err_q    <= 1'b0;
      ld_word_q   <= '0;
      ld_size_q   <= SZ_B;
      ld_zext_q   <= 1'b0;
    end else begin
      if_rvalid_q <= if_gnt;
      ld_rvalid_q <= ld_gnt;
      if (if_gnt) begin
        if_err_q   <= if_err;
        if_rdata_q <= if_err ? '0 : rom_rd_i;
      end
      if (ld_gnt) begin
        ld_err_q  <= ld_err;
        ld_word_q <= ld_err ? '0 : rom_rd_i;
        ld_size_q <= ld_size;
        ld_zext_q <= ld_unsigned_i;
      end
    end
  end

  ld_extend u_ld_extend (
    .word     (ld_word_q),
    .size     (ld_size_q),
    .zero_ext (ld_zext_q),
    .data     (ld_data)
  );

  // A response due in a cycle where reset is asserted is dropped: the
  // registered value is masked so a grant just before reset never surfaces.
  assign if_rvalid_o = if_rvalid_q & ~rst_i;
  assign if_err_o    = if_err_q    & ~rst_i;
  assign if_rdata_o  = rst_i ? '0 : if_rdata_q;
  assign ld_rvalid_o = ld_rvalid_q & ~rst_i;
  assign ld_err_o    = ld_err_q    & ~rst_i;
  assign ld_rdata_o  = rst_i ? '0 : ld_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
//   Bench for rom_arbiter: directed scenarios with literal expectations plus a
//   randomized phase, all compared every cycle against a byte-array ROM model.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned ROM_BYTES  = 4096;
  localparam int unsigned STARVE_MAX = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ld_req, ld_uns;
  logic [31:0] if_addr, ld_addr;
  logic [1:0]  ld_size;
  logic        if_gnt, if_rvalid, if_err, ld_gnt, ld_rvalid, ld_err;
  logic [31:0] if_rdata, ld_rdata, rom_a, rom_rd;
  arb_state_e  dbg_state;
  logic [7:0]  dbg_cnt;

  always #5 clk = ~clk;

  rom_arbiter #(
    .ADDR_W(ADDR_W), .ROM_BYTES(ROM_BYTES), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_size_i(ld_size),
    .ld_unsigned_i(ld_uns), .ld_gnt_o(ld_gnt),
    .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata), .ld_err_o(ld_err),
    .rom_a_o(rom_a), .rom_rd_i(rom_rd),
    .dbg_state_o(dbg_state), .dbg_starve_cnt_o(dbg_cnt)
  );

  // ---------------------------------------------------------------------------
  // ROM model: byte array, combinational read
  // ---------------------------------------------------------------------------
  logic [7:0] mem [ROM_BYTES];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    longint      p;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      p = longint'(a) + longint'(k);
      w = {w[23:0], (p < longint'(ROM_BYTES)) ? mem[int'(p)] : 8'hEE};
    end
    return w;
  endfunction

  assign rom_rd = rom_word(rom_a);

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        valid;
    logic        is_ld;
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  int          run = 0;          // consecutive cycles IF asked and was refused
  logic [31:0] if_last = '0;
  logic [31:0] ld_last = '0;
  bit          last_if_win = 0;
  bit          last_ld_win = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural rules
  function automatic bit if_error(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (longint'(a) > longint'(ROM_BYTES) - 4);
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ld_error(input logic [31:0] a, input logic [1:0] s);
    int nb;
    nb = nbytes(s);
    if (nb == 0) return 1;
    if ((longint'(a) % longint'(nb)) != 0) return 1;
    return (longint'(a) + longint'(nb) > longint'(ROM_BYTES));
  endfunction

  // Big-endian value of nb bytes starting at a, then signed or unsigned.
  function automatic logic [31:0] mem_value(input logic [31:0] a, input int nb, input bit uns);
    longint v;
    v = 0;
    for (int k = 0; k < nb; k++) v = v * 256 + longint'(mem[int'(a) + k]);
    if (!uns && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model (called once per cycle, at negedge)
  // ---------------------------------------------------------------------------
  task automatic check_cycle();
    resp_t       e;
    resp_t       n;
    bit          iw, lw;
    logic [31:0] ea;
    @(negedge clk);
    iw = !rst && if_req && (!ld_req || run >= int'(STARVE_MAX));
    lw = !rst && ld_req && !iw;
    chk("if_gnt", if_gnt, iw);
    chk("ld_gnt", ld_gnt, lw);
    ea = rst ? 32'h0 : (iw ? if_addr : ld_addr);
    chk("rom_a", rom_a, ea);

    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk("if_rvalid", if_rvalid, e.valid && !e.is_ld && !rst);
    chk("ld_rvalid", ld_rvalid, e.valid &&  e.is_ld && !rst);
    chk("dual_rvalid", if_rvalid & ld_rvalid, 0);
    if (rst) begin
      if_last = '0;
      ld_last = '0;
    end else if (e.valid) begin
      if (e.is_ld) begin
        ld_last = e.data;
        chk("ld_err", ld_err, e.err);
      end else begin
        if_last = e.data;
        chk("if_err", if_err, e.err);
      end
    end
    chk("if_rdata", if_rdata, if_last);
    chk("ld_rdata", ld_rdata, ld_last);

    n = '0;
    if (iw) begin
      n.valid = 1; n.is_ld = 0;
      n.err   = if_error(if_addr);
      n.data  = n.err ? 32'h0 : mem_value(if_addr, 4, 1);
    end else if (lw) begin
      n.valid = 1; n.is_ld = 1;
      n.err   = ld_error(ld_addr, ld_size);
      n.data  = n.err ? 32'h0 : mem_value(ld_addr, nbytes(ld_size), ld_uns);
    end
    exp_q.push_back(n);

    run = (rst || !if_req || iw) ? 0 : run + 1;
    last_if_win = iw;
    last_ld_win = lw;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    if_req = 0;
    ld_req = 0;
    repeat (n) begin
      check_cycle();
      advance();
    end
  endtask

  task automatic do_if(input logic [31:0] a, input logic [31:0] ed, input bit ee);
    if_req = 1; if_addr = a; ld_req = 0;
    check_cycle();
    chk("dir_if_gnt", if_gnt, 1);
    advance();
    if_req = 0;
    check_cycle();
    chk("dir_if_rvalid", if_rvalid, 1);
    chk("dir_if_rdata", if_rdata, ed);
    chk("dir_if_err", if_err, ee);
    advance();
  endtask

  task automatic do_ld(input logic [31:0] a, input logic [1:0] s, input bit u,
                       input logic [31:0] ed, input bit ee);
    ld_req = 1; ld_addr = a; ld_size = s; ld_uns = u; if_req = 0;
    check_cycle();
    chk("dir_ld_gnt", ld_gnt, 1);
    advance();
    ld_req = 0;
    check_cycle();
    chk("dir_ld_rvalid", ld_rvalid, 1);
    chk("dir_ld_rdata", ld_rdata, ed);
    chk("dir_ld_err", ld_err, ee);
    advance();
  endtask

  // Both ports request continuously: LD, LD, LD, IF, repeating.
  task automatic contend(input int n);
    if_req = 1; if_addr = 32'h10;
    ld_req = 1; ld_addr = 32'h20; ld_size = 2'd2; ld_uns = 0;
    for (int i = 0; i < n; i++) begin
      check_cycle();
      chk("cont_ld_gnt", ld_gnt, (i % 4) != 3);
      chk("cont_if_gnt", if_gnt, (i % 4) == 3);
      chk("cont_ld_rvalid", ld_rvalid, (i > 0) && (((i - 1) % 4) != 3));
      chk("cont_if_rvalid", if_rvalid, (i > 0) && (((i - 1) % 4) == 3));
      advance();
    end
  endtask

  function automatic logic [31:0] rand_if_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom();
    if (r == 1) return ROM_BYTES - 4 + $urandom_range(0, 7);
    return $urandom_range(0, ROM_BYTES / 4 - 1) * 4;
  endfunction

  function automatic logic [31:0] rand_ld_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom();
    if (r == 1) return ROM_BYTES - $urandom_range(1, 4);
    if (r == 2) return 32'hFFFF_FFFC + $urandom_range(0, 3);
    return $urandom_range(0, ROM_BYTES - 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < int'(ROM_BYTES); i++) mem[i] = 8'($urandom());
    {mem[16], mem[17], mem[18], mem[19]}         = 32'h0050_0093;
    {mem[32], mem[33], mem[34], mem[35]}         = 32'h807F_1234;
    {mem[4092], mem[4093], mem[4094], mem[4095]} = 32'hDEAD_BEEF;

    rst = 1; if_req = 1; ld_req = 1;
    if_addr = 32'h10; ld_addr = 32'h20; ld_size = 2'd0; ld_uns = 0;
    advance();
    advance();
    repeat (2) begin
      check_cycle();
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_ld_gnt", ld_gnt, 0);
      chk("rst_rom_a", rom_a, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_ld_rvalid", ld_rvalid, 0);
      chk("rst_state", dbg_state, LD_PRIO);
      chk("rst_starve", dbg_cnt, 0);
      advance();
    end
    rst = 0;
    idle(2);

    do_if(32'h10, 32'h0050_0093, 0);
    do_ld(32'h20, 2'd0, 0, 32'hFFFF_FF80, 0);
    do_ld(32'h20, 2'd0, 1, 32'h0000_0080, 0);
    do_ld(32'h21, 2'd0, 0, 32'h0000_007F, 0);
    do_ld(32'h20, 2'd1, 0, 32'hFFFF_807F, 0);
    do_ld(32'h22, 2'd1, 1, 32'h0000_1234, 0);
    do_ld(32'h20, 2'd2, 0, 32'h807F_1234, 0);
    do_ld(32'h22, 2'd2, 0, 32'h0, 1);
    do_ld(32'hFFF, 2'd1, 0, 32'h0, 1);
    do_ld(32'hFFF, 2'd0, 1, 32'h0000_00EF, 0);
    do_ld(32'hFFE, 2'd1, 0, 32'hFFFF_BEEF, 0);
    do_if(32'hFFC, 32'hDEAD_BEEF, 0);
    do_if(32'h1000, 32'h0, 1);
    do_if(32'h12, 32'h0, 1);
    do_ld(32'h20, 2'd3, 0, 32'h0, 1);
    do_ld(32'hFFFF_FFFC, 2'd2, 0, 32'h0, 1);
    idle(1);

    contend(8);
    idle(2);

    // Reset right after an LD grant: its response must never appear.
    if_req = 1; ld_req = 1; if_addr = 32'h10; ld_addr = 32'h20; ld_size = 2'd2;
    check_cycle();
    chk("pre_rst_ld_gnt", ld_gnt, 1);
    advance();
    check_cycle();
    chk("pre_rst_ld_gnt", ld_gnt, 1);
    advance();
    rst = 1;
    check_cycle();
    chk("mid_rst_ld_rvalid", ld_rvalid, 0);
    chk("mid_rst_if_gnt", if_gnt, 0);
    chk("mid_rst_ld_gnt", ld_gnt, 0);
    advance();
    rst = 0;
    contend(8);
    idle(2);

    // Randomized traffic; each requester holds until granted.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!if_req || last_if_win) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = rand_if_addr();
      end
      if (!ld_req || last_ld_win) begin
        ld_req  = ($urandom_range(0, 99) < 60);
        ld_addr = rand_ld_addr();
        ld_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        ld_uns  = 1'($urandom_range(0, 1));
      end
      check_cycle();
      advance();
    end
    rst = 0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
